uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Parametrised UART receiver. Replaces the divided-clock (toggled uart_clock) scheme with a single-clock design.
- Runs entirely on clk and uses a clock-enable oversampling tick.
- Synchronises RX, validates the start bit, majority-samples each bit and checks the stop bit.
- Buffers received words in a small FIFO with a valid/ready handshake toward the consumer logic (LED/PMOD debug, command decoders).

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit. Even, >= 8.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- STOP_BITS, 1, stop bits checked, 1 or 2.
- FIFO_DEPTH, 4, receive FIFO entries. Power of two, >= 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Used only with UART_RX_PARITY_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  FIFO head word.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts head when rx_valid && rx_ready.
- frame_err  output  1  1-cycle pulse: stop bit sampled 0, word discarded.
- parity_err  output  1  1-cycle pulse: parity mismatch, word discarded.
- overrun  output  1  1-cycle pulse: good word arrived while FIFO full, word dropped.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset:
  - Synchroniser flops reset to 1.
  - FSM goes to IDLE; tick and bit counters go to 0; FIFO is emptied.
  - All outputs are 0, including rx_data.
- Synchroniser: two flops on rx; all logic uses the second-stage output rs.
- Tick generator:
  - DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), width $clog2(DIV). Defaults give DIV = 54, so 864 clk per bit.
  - Counter runs 0..DIV-1; tick is asserted for one cycle at DIV-1.
  - Counter is forced to 0 on the start-edge detect so sampling phase aligns to the frame.
- Sample counter s counts 0..OVERSAMPLE-1 on ticks. The bit value is the majority of rs at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM transitions:
  - IDLE -> START on a falling edge of rs (previous 1, current 0).
  - START: at the majority decision, value 1 means glitch and returns to IDLE with no error; value 0 continues. At s wrap, go to DATA.
  - DATA: shift each decided bit in LSB first. After DATA_BITS bits go to PARITY if enabled, else to STOP.
  - PARITY: compare the decided bit with XOR(data)^PARITY_ODD, then go to STOP.
  - STOP: at the decision point of each stop bit:
    - A 0 pulses frame_err and returns to IDLE immediately.
    - After the last stop bit decides 1, commit the word and return to IDLE at the decision point, not at the bit end, so back-to-back frames resync.
- Error precedence: frame_err overrides parity_err; only one pulse per frame.
- Commit:
  - If FIFO is not full, write the word. rx_valid/rx_data reflect it the cycle after the commit when the FIFO was empty.
  - If FIFO is full, pulse overrun and drop the new word; the FIFO contents are unchanged.
  - Push and pop in the same cycle while full: the pop frees space, the push is accepted and count is unchanged.
  - Push and pop while empty: not possible, since rx_valid=0.
- FIFO: pointer width $clog2(FIFO_DEPTH)+1; wrap-around via the pointer MSB. rx_data is the registered head.
- Reset mid-frame: the partial word is discarded with no error pulse. The FSM restarts in IDLE and needs a fresh falling edge.
- rx stuck low (break): one frame_err, then IDLE until rs returns high, because the edge detect needs a 1 -> 0 transition.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state is present, frames carry DATA_BITS+1 bits before the stop bit, and parity mismatch pulses parity_err and discards the word.
- Undefined: the PARITY state and logic are removed and parity_err is tied 0.

Decomposition:
- Package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Divisor computation function.
  - Majority-sample index constants.
- Sub-module uart_rx_fifo: synchronous FIFO, parametrised by width and depth, with overrun/full/empty logic.
- Tick generator and FSM stay in uart_rx_core.

Test Plan:
- Defaults, send 0x55 (8N1):
  - rx_valid rises within 2 clk after the mid-stop-bit decision with rx_data=0x55.
  - No error pulses.
  - busy low again before the next start edge.
- Glitch: rx low for 300 clk (< half bit of 432), then high -> FSM returns to IDLE, no rx_valid, no frame_err.
- Stop bit driven 0 on frame 0xA3 -> one frame_err pulse, FIFO stays empty, the next valid frame 0x3C is received correctly.
- rx_ready held 0 and 5 frames 0x01..0x05 sent (FIFO_DEPTH=4):
  - The 5th frame pulses overrun.
  - Draining then yields 0x01,0x02,0x03,0x04 in order.
- Reset asserted mid-DATA of frame 0xFF, released, frame 0x81 sent -> only 0x81 appears, no error pulses.
- With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err pulse, word dropped. Send 0x07 with parity bit 1 -> 0x07 delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, baud divisor and
// majority-sample positions within one oversampled bit.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Offsets around the bit centre (OVERSAMPLE/2) used for the 2-of-3 vote.
  localparam int MAJ_OFS_LO  = -1;
  localparam int MAJ_OFS_MID = 0;
  localparam int MAJ_OFS_HI  = 1;

  // Rounded clk cycles per oversample tick.
  function automatic int calc_div(input longint clk_hz, input longint baud, input int os);
    longint den;
    den = baud * longint'(os);
    return int'((clk_hz + den / 2) / den);
  endfunction

  function automatic int sample_index(input int os, input int ofs);
    return os / 2 + ofs;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO; a push while full (and not popping) is dropped
// and reported as a one-cycle overrun pulse.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push && !do_push;
      if (do_push) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Single-clock oversampling UART receiver feeding a valid/ready FIFO.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS + 1);
  localparam logic [S_W-1:0] S_LO  = S_W'(sample_index(OVERSAMPLE, MAJ_OFS_LO));
  localparam logic [S_W-1:0] S_MID = S_W'(sample_index(OVERSAMPLE, MAJ_OFS_MID));
  localparam logic [S_W-1:0] S_HI  = S_W'(sample_index(OVERSAMPLE, MAJ_OFS_HI));
  localparam logic [S_W-1:0] S_END = S_W'(OVERSAMPLE - 1);

  rx_state_t            state, next_state;
  logic                 rx_meta, rs, rs_d;
  logic [DIV_W-1:0]     tick_cnt;
  logic                 tick;
  logic [S_W-1:0]       s;
  logic [1:0]           samp;
  logic                 bit_val;
  logic                 decide, wrap, start_edge;
  logic [BC_W-1:0]      bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 push, frame_set, parity_set;
  logic                 fifo_empty, fifo_full;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
`endif

  assign tick       = (tick_cnt == DIV_W'(DIV - 1));
  assign decide     = tick && (s == S_HI);
  assign wrap       = tick && (s == S_END);
  assign start_edge = (state == ST_IDLE) && rs_d && !rs;
  assign bit_val    = (samp[0] & samp[1]) | (samp[0] & rs) | (samp[1] & rs);
  assign busy       = (state != ST_IDLE);
  assign rx_valid   = !fifo_empty;

  // Next-state logic; a word is committed at the last stop bit's centre so the
  // FSM is back in IDLE in time to catch a back-to-back start edge.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    case (state)
      ST_IDLE:  if (start_edge) next_state = ST_START;
      ST_START: begin
        if (decide && bit_val) next_state = ST_IDLE;
        else if (wrap)         next_state = ST_DATA;
      end
      ST_DATA: begin
        if (wrap && (bit_cnt == BC_W'(DATA_BITS))) begin
`ifdef UART_RX_PARITY_EN
          next_state = ST_PARITY;
`else
          next_state = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (wrap) next_state = ST_STOP;
`endif
      ST_STOP: begin
        if (decide) begin
          if (!bit_val) begin
            frame_set  = 1'b1;
            next_state = ST_IDLE;
          end else if (stop_cnt == 1'(STOP_BITS - 1)) begin
            next_state = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad) parity_set = 1'b1;
            else            push       = 1'b1;
`else
            push = 1'b1;
`endif
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Synchroniser, tick/sample counters, shift register and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rs         <= 1'b1;
      rs_d       <= 1'b1;
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      s          <= '0;
      samp       <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rs         <= rx_meta;
      rs_d       <= rs;
      state      <= next_state;
      frame_err  <= frame_set;
      parity_err <= parity_set;

      if (start_edge || tick) tick_cnt <= '0;
      else                    tick_cnt <= tick_cnt + DIV_W'(1);

      if (start_edge) s <= '0;
      else if (tick)  s <= (s == S_END) ? '0 : s + S_W'(1);

      if (tick && (s == S_LO))  samp[0] <= rs;
      if (tick && (s == S_MID)) samp[1] <= rs;

      if (start_edge) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
      end
      if ((state == ST_DATA) && decide) begin
        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BC_W'(1);
      end
      if ((state == ST_STOP) && decide) stop_cnt <= stop_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
      if ((state == ST_PARITY) && decide)
        parity_bad <= bit_val ^ (^shreg) ^ PARITY_ODD[0];
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_valid && rx_ready),
    .head      (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core (8N1, FIFO_DEPTH 4, 160 clk per bit).
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 10000;
  localparam int OS     = 16;
  localparam int DIV    = 10;
  localparam int BIT    = DIV * OS;
  // Stop-bit vote is global tick 9*OS+OS/2+1; 2 sync flops + 1 edge register ahead of it.
  localparam int DEC    = 2 + DIV * (9 * OS + OS / 2 + 2);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = 0;
  logic       valid_q = 1'b0;
  int         n_ferr = 0, n_perr = 0, n_ovr = 0;
  logic [7:0] got_q[$];
  int         base, f0, p0, o0;

  uart_rx_core #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe pulses, handshakes and the first cycle of each rx_valid assertion.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (overrun)    n_ovr++;
      if (rx_valid && !valid_q) rise_cyc = cyc;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end
    valid_q = rx_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input bit with_par, input logic par_bit);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT) @(negedge clk);
    end
    if (with_par) begin
      rx = par_bit;
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_pulses", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame 0x55 with latency check
    base = got_q.size(); f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    checkOutput("f55_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) checkOutput("f55_data", 32'(got_q[base]), 32'h55);
    checkOutput("f55_latency_ok", 32'((rise_cyc - start_cyc >= DEC + 1) && (rise_cyc - start_cyc <= DEC + 2)), 32'd1);
    checkOutput("f55_errors", 32'((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)), 32'd0);
    checkOutput("f55_busy_idle", 32'(busy), 32'd0);

    // Short glitch shorter than half a bit
    base = got_q.size(); f0 = n_ferr;
    @(negedge clk);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checkOutput("glitch_busy", 32'(busy), 32'd0);
    checkOutput("glitch_no_word", 32'(got_q.size() - base), 32'd0);
    checkOutput("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);

    // Bad stop bit, then a good frame
    base = got_q.size(); f0 = n_ferr;
    applyStimulus(8'hA3, 1'b0, 1'b0, 1'b0);
    checkOutput("ferr_pulse", 32'(n_ferr - f0), 32'd1);
    checkOutput("ferr_no_word", 32'(got_q.size() - base), 32'd0);
    checkOutput("ferr_rx_valid", 32'(rx_valid), 32'd0);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
    checkOutput("after_ferr_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) checkOutput("after_ferr_data", 32'(got_q[base]), 32'h3C);
    checkOutput("after_ferr_total_ferr", 32'(n_ferr - f0), 32'd1);

    // Fill the FIFO, overrun on the fifth word, then drain
    base = got_q.size(); o0 = n_ovr;
    rx_ready = 1'b0;
    for (int k = 1; k <= 4; k++) applyStimulus(8'(k), 1'b1, 1'b0, 1'b0);
    checkOutput("fill_no_overrun", 32'(n_ovr - o0), 32'd0);
    applyStimulus(8'h05, 1'b1, 1'b0, 1'b0);
    checkOutput("overrun_pulse", 32'(n_ovr - o0), 32'd1);
    checkOutput("full_rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("full_head", 32'(rx_data), 32'h01);
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("drain_count", 32'(got_q.size() - base), 32'd4);
    for (int k = 0; k < 4; k++)
      if (got_q.size() > base + k)
        checkOutput($sformatf("drain_word%0d", k), 32'(got_q[base + k]), 32'(k + 1));
    checkOutput("drain_empty", 32'(rx_valid), 32'd0);

    // Reset in the middle of a frame
    base = got_q.size(); f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    fork
      applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
      begin
        repeat (3 * BIT) @(negedge clk);
        checkOutput("midframe_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
    join
    applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_mid_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) checkOutput("rst_mid_data", 32'(got_q[base]), 32'h81);
    checkOutput("rst_mid_errors", 32'((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a parity bit of 1
    base = got_q.size(); p0 = n_perr;
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
    checkOutput("par_bad_pulse", 32'(n_perr - p0), 32'd1);
    checkOutput("par_bad_dropped", 32'(got_q.size() - base), 32'd0);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
    checkOutput("par_good_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) checkOutput("par_good_data", 32'(got_q[base]), 32'h07);
    checkOutput("par_good_no_pulse", 32'(n_perr - p0), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
